fp16_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `float_add` half-precision adder between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, registers its operands into the shared `float_add` instance, captures the sum, and returns it on a single tagged response channel. One operation is in flight at a time. The block sits between the compute clients and the adder datapath.

---
 rtl/fp16_add_arbiter_if.sv | 27 ++
 rtl/fp16_add_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_fp16_add_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_add_arbiter_if.sv
// Requester/response bundle for fp16_add_arbiter: NUM_REQ operand ports in,
// one tagged result port out.
interface fp16_add_arbiter_if #(
    parameter int FLOAT_WIDTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0][FLOAT_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][FLOAT_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                  req_sub;
    logic                                resp_valid;
    logic                                resp_ready;
    logic [FLOAT_WIDTH-1:0]              resp_data;
    logic [ID_WIDTH-1:0]                 resp_id;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin sharing of one float_add among NUM_REQ requesters, one op in flight.
// Optional macro FADD_ARB_SUB_EN: per-request subtract (flips B's sign before the adder).

module float_add #(
    parameter int FLOAT_WIDTH    = 16,
    parameter int MANTISSA_WIDTH = 10,
    parameter int EXPONENT_WIDTH = 5
) (
    input  logic [FLOAT_WIDTH-1:0]    float_a,
    input  logic [FLOAT_WIDTH-1:0]    float_b,
    output logic [FLOAT_WIDTH-1:0]    res,
    output logic [MANTISSA_WIDTH+4:0] fraction_sum
);
    localparam int MW = MANTISSA_WIDTH;
    localparam int EW = EXPONENT_WIDTH;
    // hidden bit + fraction + guard/round/sticky
    localparam int SW = MW + 4;

    logic          sa, sb;
    logic [EW-1:0] ea, eb, ea_eff, eb_eff;
    logic [MW-1:0] fa, fb;
    logic [SW-1:0] ma, mb;

    assign {sa, ea, fa} = float_a;
    assign {sb, eb, fb} = float_b;
    assign ea_eff = (ea == '0) ? EW'(1) : ea;
    assign eb_eff = (eb == '0) ? EW'(1) : eb;
    assign ma     = {|ea, fa, 3'b000};
    assign mb     = {|eb, fb, 3'b000};

    logic          a_ge, s_l, s_s, sub_op, g, r, st;
    logic [EW-1:0] e_l, e_s, diff;
    logic [SW-1:0] m_l, m_s, m_sh, mask, norm;
    logic [SW:0]   raw;
    logic [EW+1:0] e_w, e_out;
    logic [MW+1:0] rnd;
    logic [MW-1:0] frac;
    logic          a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_ge   = {ea, fa} >= {eb, fb};
        s_l    = a_ge ? sa : sb;
        s_s    = a_ge ? sb : sa;
        e_l    = a_ge ? ea_eff : eb_eff;
        e_s    = a_ge ? eb_eff : ea_eff;
        m_l    = a_ge ? ma : mb;
        m_s    = a_ge ? mb : ma;
        diff   = e_l - e_s;
        mask   = ~({SW{1'b1}} << diff);
        if (int'(diff) >= SW) m_sh = {{(SW-1){1'b0}}, |m_s};
        else                  m_sh = (m_s >> diff) | {{(SW-1){1'b0}}, |(m_s & mask)};

        // magnitude ordering above guarantees the subtraction never goes negative
        sub_op = s_l ^ s_s;
        raw    = sub_op ? ({1'b0, m_l} - {1'b0, m_sh}) : ({1'b0, m_l} + {1'b0, m_sh});
        e_w    = {2'b00, e_l};

        if (raw[SW]) begin
            norm = raw[SW:1] | {{(SW-1){1'b0}}, raw[0]};
            e_w  = e_w + 1'b1;
        end else begin
            norm = raw[SW-1:0];
            for (int i = 0; i < SW; i++) begin
                if (!norm[SW-1] && e_w > (EW+2)'(1)) begin
                    norm = norm << 1;
                    e_w  = e_w - 1'b1;
                end
            end
        end

        g   = norm[2];
        r   = norm[1];
        st  = norm[0];
        rnd = {1'b0, norm[SW-1:3]} + (MW+2)'(g & (r | st | norm[3]));
        if (rnd[MW+1]) begin
            e_out = e_w + 1'b1;
            frac  = '0;
        end else begin
            e_out = rnd[MW] ? e_w : '0;
            frac  = rnd[MW-1:0];
        end

        res = {s_l, e_out[EW-1:0], frac};
        if (e_out >= (EW+2)'((1 << EW) - 1)) res = {s_l, {EW{1'b1}}, {MW{1'b0}}};
        if (raw == '0)                       res = {sa & sb, {(FLOAT_WIDTH-1){1'b0}}};

        a_nan = (&ea) && (fa != '0);
        b_nan = (&eb) && (fb != '0);
        a_inf = (&ea) && (fa == '0);
        b_inf = (&eb) && (fb == '0);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        else if (a_inf)
            res = float_a;
        else if (b_inf)
            res = float_b;

        fraction_sum = raw;
    end
endmodule

module fp16_add_arbiter #(
    parameter int FLOAT_WIDTH    = 16,
    parameter int MANTISSA_WIDTH = 10,
    parameter int EXPONENT_WIDTH = 5,
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2
) (
    input  logic                clk,
    input  logic                rst,
    fp16_add_arbiter_if.slave   bus,
    output logic                busy,
    output logic [15:0]         op_count
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] a;
        logic [FLOAT_WIDTH-1:0] b;
    } op_t;

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FLOAT_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [15:0]            op_count_q, op_count_d;

    logic                   grant_vld;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [NUM_REQ-1:0]     ready;
    logic [FLOAT_WIDTH-1:0] add_b, add_res;

`ifdef FADD_ARB_SUB_EN
    logic sub_q, sub_d;
`else
    logic unused_sub;
    assign unused_sub = ^bus.req_sub;
`endif

    // first valid requester at or above rr_ptr, wrapping
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == S_IDLE && grant_vld) ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        op_count_d  = op_count_q;
`ifdef FADD_ARB_SUB_EN
        sub_d       = sub_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    op_d.a   = bus.req_a[grant_id];
                    op_d.b   = bus.req_b[grant_id];
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d  = S_EXEC;
`ifdef FADD_ARB_SUB_EN
                    sub_d    = bus.req_sub[grant_id];
`endif
                end
            end
            S_EXEC: begin
                resp_data_d = add_res;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            op_count_q  <= '0;
`ifdef FADD_ARB_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            op_count_q  <= op_count_d;
`ifdef FADD_ARB_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

`ifdef FADD_ARB_SUB_EN
    assign add_b = {op_q.b[FLOAT_WIDTH-1] ^ sub_q, op_q.b[FLOAT_WIDTH-2:0]};
`else
    assign add_b = op_q.b;
`endif

    float_add #(
        .FLOAT_WIDTH   (FLOAT_WIDTH),
        .MANTISSA_WIDTH(MANTISSA_WIDTH),
        .EXPONENT_WIDTH(EXPONENT_WIDTH)
    ) u_add (
        .float_a     (op_q.a),
        .float_b     (add_b),
        .res         (add_res),
        .fraction_sum()
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = id_q;
    assign busy           = (state_q != S_IDLE);
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter: latency, round-robin order, stall,
// subtract option, mid-op reset and op_count wrap.
module tb_fp16_add_arbiter;
    localparam int FW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

`ifdef FADD_ARB_SUB_EN
    localparam logic [15:0] SUB_EXP = 16'h4000;
`else
    localparam logic [15:0] SUB_EXP = 16'h4400;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] op_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    fp16_add_arbiter_if #(.FLOAT_WIDTH(FW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    fp16_add_arbiter #(
        .FLOAT_WIDTH(FW), .MANTISSA_WIDTH(10), .EXPONENT_WIDTH(5),
        .NUM_REQ(NR), .ID_WIDTH(IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .busy    (busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, output logic [15:0] data, output logic [IW-1:0] id);
        int n;
        bus.req_a[idx]     = a;
        bus.req_b[idx]     = b;
        bus.req_sub[idx]   = sub;
        bus.req_valid[idx] = 1'b1;
        bus.resp_ready     = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[idx] && n < 20) begin tick(); n++; end
        if (n >= 20) chk("accept_timeout", 0, 1);
        tick();
        bus.req_valid[idx] = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin tick(); n++; end
        if (n >= 20) chk("resp_timeout", 0, 1);
        data = bus.resp_data;
        id   = bus.resp_id;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]   d, c0;
        logic [IW-1:0] id;
        logic [15:0]   exp_sum [NR];
        int            grant [5];
        int            rid [5];
        logic [15:0]   rdata [5];
        int            ng, nr, seen;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_sub    = '0;
        bus.resp_ready = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_data",  bus.resp_data, 0);
        chk("rst_id",    bus.resp_id, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_count", op_count, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // single request, exact latency
        bus.req_a[0] = 16'h3C00;
        bus.req_b[0] = 16'h3C00;
        bus.req_valid[0] = 1'b1;
        #1;
        chk("one_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        chk("one_exec_busy",  busy, 1);
        chk("one_exec_valid", bus.resp_valid, 0);
        chk("one_exec_ready", bus.req_ready, 0);
        tick();
        chk("one_valid", bus.resp_valid, 1);
        chk("one_data",  bus.resp_data, 16'h4000);
        chk("one_id",    bus.resp_id, 0);
        tick();
        chk("one_done_valid", bus.resp_valid, 0);
        chk("one_count",      op_count, 1);
        chk("one_done_busy",  busy, 0);

        // round-robin with all four requesters valid, starting from fresh rr_ptr
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        bus.req_a = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        bus.req_b = {16'h4400, 16'h3C00, 16'h3C00, 16'h3C00};
        exp_sum[0] = 16'h4000;
        exp_sum[1] = 16'h4200;
        exp_sum[2] = 16'h4400;
        exp_sum[3] = 16'h4800;
        bus.req_valid = 4'b1111;
        #1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 60 && nr < 5; cyc++) begin
            if (bus.req_ready != 0 && ng < 5) begin
                for (int j = 0; j < NR; j++) if (bus.req_ready[j]) grant[ng] = j;
                ng++;
            end
            if (bus.resp_valid) begin
                rid[nr]   = int'(bus.resp_id);
                rdata[nr] = bus.resp_data;
                nr++;
            end
            if (nr == 5) bus.req_valid = '0;
            else begin @(posedge clk); #2; end
        end
        if (nr < 5 || ng < 5) chk("rr_timeout", nr, 5);
        for (int k = 0; k < 5 && k < nr && k < ng; k++) begin
            chk($sformatf("rr_grant%0d", k), grant[k], k % NR);
            chk($sformatf("rr_id%0d", k),    rid[k],   k % NR);
            chk($sformatf("rr_data%0d", k),  rdata[k], exp_sum[k % NR]);
        end
        tick();

        // back-pressure: hold RESP for 5 cycles with another requester waiting
        bus.resp_ready = 1'b0;
        bus.req_a[2] = 16'h4200;
        bus.req_b[2] = 16'h3C00;
        bus.req_sub[2] = 1'b0;
        bus.req_valid[2] = 1'b1;
        #1;
        ng = 0;
        while (!bus.req_ready[2] && ng < 20) begin tick(); ng++; end
        tick();
        bus.req_valid[2] = 1'b0;
        ng = 0;
        while (!bus.resp_valid && ng < 20) begin tick(); ng++; end
        if (ng >= 20) chk("bp_timeout", 0, 1);
        c0 = op_count;
        bus.req_a[0] = 16'h3C00;
        bus.req_b[0] = 16'h3C00;
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_data",  bus.resp_data, 16'h4400);
            chk("bp_id",    bus.resp_id, 2);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_count", op_count, c0);
        end
        bus.req_valid[0] = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_release_count", op_count, c0 + 16'd1);
        chk("bp_release_valid", bus.resp_valid, 0);

        // subtract select
        run_op(3, 16'h4200, 16'h3C00, 1'b1, d, id);
        chk("sub_data", d, SUB_EXP);
        chk("sub_id",   id, 3);

        // asynchronous reset while in EXEC
        bus.req_a[1] = 16'h3C00;
        bus.req_b[1] = 16'h3C00;
        bus.req_valid[1] = 1'b1;
        #1;
        ng = 0;
        while (!bus.req_ready[1] && ng < 20) begin tick(); ng++; end
        tick();
        bus.req_valid[1] = 1'b0;
        chk("rexec_busy_pre", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("rexec_valid", bus.resp_valid, 0);
        chk("rexec_busy",  busy, 0);
        chk("rexec_data",  bus.resp_data, 0);
        chk("rexec_id",    bus.resp_id, 0);
        chk("rexec_count", op_count, 0);
        chk("rexec_ready", bus.req_ready, 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin tick(); if (bus.resp_valid) seen++; end
        chk("rexec_no_resp", seen, 0);
        bus.req_a[3] = 16'h3C00;
        bus.req_b[3] = 16'h3C00;
        bus.req_valid[3] = 1'b1;
        bus.req_a[0] = 16'h3C00;
        bus.req_b[0] = 16'h4000;
        bus.req_sub[0] = 1'b0;
        bus.req_valid[0] = 1'b1;
        #1;
        chk("rexec_grant0", bus.req_ready, 4'b0001);
        bus.req_valid[3] = 1'b0;
        tick();
        run_op(0, 16'h3C00, 16'h4000, 1'b0, d, id);
        chk("rexec_op_data", d, 16'h4200);
        chk("rexec_op_id",   id, 0);

        // op_count wrap
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count_q;
        #1;
        chk("wrap_pre", op_count, 16'hFFFF);
        run_op(2, 16'h3C00, 16'h3C00, 1'b0, d, id);
        chk("wrap_data",  d, 16'h4000);
        chk("wrap_count", op_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
